character_sprite_drawer: RTL and testbench
==========================================

// Module: character_sprite_drawer
// PURPOSE
//  Consumes the 4-bit CurrState of the character movement FSM and turns position changes into a
//  pixel stream for the VGA adapter: erases the sprite box at the old lane, then draws it at the new lane.
//  Sits between the character FSM and the VGA adapter's X/Y/Colour/Plot inputs.
//  Transition codes (4-9) and unused codes (10-15) never cause drawing.
// PARAMETERS
//  SPRITE_W     8       sprite width in pixels (>=1)
//  SPRITE_H     8       sprite height in pixels (>=1)
//  LANE_X0      16      X of left edge of lane 0
//  LANE_PITCH   32      X distance between adjacent lanes
//  CHAR_Y       100     Y of top edge of sprite (same in all lanes)
//  CHAR_COLOUR  3'b111  sprite colour
//  BG_COLOUR    3'b000  erase colour
// PORTS
//  Clock      in   1  system clock, all state on rising edge
//  Reset      in   1  asynchronous, active-high
//  CurrState  in   4  character FSM state: 0-3 = lane position, 4-9 = in transition, 10-15 = unused
//  X          out  8  pixel X to VGA adapter (registered)
//  Y          out  7  pixel Y to VGA adapter (registered)
//  Colour     out  3  pixel colour (registered)
//  Plot       out  1  high for exactly one cycle per pixel to write
//  Busy       out  1  high while an erase/draw sweep is in progress
// BEHAVIOUR
//  - Reset (async): X=0, Y=0, Colour=0, Plot=0, Busy=0; FSM -> IDLE; Shown=0; ShownPos=0; counters 0.
//  - States: IDLE, ERASE, DRAW. Shown flags a sprite on screen; ShownPos (2b) is its lane.
//  - IDLE: CurrState sampled only here. Sweep starts only if CurrState<=3 AND (!Shown OR CurrState[1:0]!=ShownPos).
//    Shown=1: latch Target=CurrState[1:0], go ERASE at ShownPos. Shown=0: latch Target, go DRAW.
//    Otherwise stay IDLE, Plot=0.
//  - Sweep: counters cx 0..SPRITE_W-1 (inner), cy 0..SPRITE_H-1 (outer), row-major, one pixel per clock.
//    Each sweep cycle registers X=LANE_X0+lane*LANE_PITCH+cx, Y=CHAR_Y+cy, Plot=1.
//    ERASE uses ShownPos + BG_COLOUR; DRAW uses Target + CHAR_COLOUR.
//  - Timing: IDLE decides at edge k; first pixel valid after edge k+1; Plot high SPRITE_W*SPRITE_H
//    consecutive cycles per sweep. ERASE->DRAW has no gap (2*W*H contiguous Plot cycles).
//  - After the last DRAW pixel: ShownPos<=Target, Shown<=1, -> IDLE. Plot=0 on the next cycle.
//  - Busy=1 from edge k+1 up to and including the last Plot cycle; Busy=0 in IDLE.
//  - CurrState changes during a sweep are ignored. The sweep completes with the latched Target.
//    Back in IDLE the current CurrState is re-evaluated, so a final mismatch triggers a new sweep.
//  - X/Y arithmetic is unsigned and truncates to port width (wraps mod 256 / mod 128).
//    Parameters must keep all 4 lanes within 160x120; no clipping is done.
//  - Reset mid-sweep: outputs drop to reset values immediately (async) and Shown=0.
//    After release, the current lane is drawn without an erase (the partial box stays on screen by design).
// TESTING
//  1 Reset, CurrState=0 -> no erase; 64 Plot cycles, X 16..23 x Y 100..107 row-major,
//    Colour=111, Busy high 64 cycles, then Plot=0.
//  2 After 1, CurrState 0->4 (hold 20 cycles)->1 -> no Plot during 4; then 64 pixels at X16..23 Colour=000,
//    immediately 64 at X48..55 Colour=111; Busy high 128 cycles.
//  3 CurrState=10..15 or held at drawn lane for 100 cycles -> Plot=0, Busy=0 throughout.
//  4 Mid-DRAW of lane 1, CurrState goes 6->2 -> lane-1 sweep completes unchanged;
//    next cycle in IDLE starts erase lane1 (X48..55) + draw lane2 (X80..87).
//  5 Assert Reset on pixel 30 of an ERASE -> Plot/X/Y/Colour/Busy=0 without waiting for an edge;
//    after release with CurrState=3 -> only 64 draw pixels at X112..119.
//  6 Lane 3 -> 0 direct (CurrState 3->9->2->7->1->5->0 one step per 200 cycles) -> three erase/draw
//    pairs in order 3->2, 2->1, 1->0; final box at X16..23.

Source files
------------

// File: rtl/character_sprite_drawer.sv
// Turns lane changes of the character FSM into VGA pixel writes: the old sprite box is
// erased, then the box is drawn at the new lane, one pixel per clock.
module character_sprite_drawer #(
  parameter int unsigned SPRITE_W    = 8,
  parameter int unsigned SPRITE_H    = 8,
  parameter int unsigned LANE_X0     = 16,
  parameter int unsigned LANE_PITCH  = 32,
  parameter int unsigned CHAR_Y      = 100,
  parameter logic [2:0]  CHAR_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] CurrState,
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic [2:0] Colour,
  output logic       Plot,
  output logic       Busy
);

  localparam int unsigned CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW} drawState_t;

  drawState_t state, stateNext;

  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic [1:0]     target;
  logic [1:0]     shownPos;
  logic           shown;

  logic           startSweep;
  logic           lastPix;
  logic           rowEnd;
  logic [1:0]     lane;
  logic [7:0]     xPix;
  logic [6:0]     yPix;
  logic [2:0]     pixColour;

  always_comb begin
    startSweep = (CurrState <= 4'd3) && (!shown || (CurrState[1:0] != shownPos));
    rowEnd     = (cx == CXW'(SPRITE_W - 1));
    lastPix    = rowEnd && (cy == CYW'(SPRITE_H - 1));
    lane       = (state == ERASE) ? shownPos : target;
    pixColour  = (state == ERASE) ? BG_COLOUR : CHAR_COLOUR;
    // Position arithmetic is done at port width so it wraps like the adapter coordinates.
    xPix       = 8'(LANE_X0) + 8'(lane) * 8'(LANE_PITCH) + 8'(cx);
    yPix       = 7'(CHAR_Y) + 7'(cy);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startSweep) stateNext = shown ? ERASE : DRAW;
      ERASE:   if (lastPix) stateNext = DRAW;
      DRAW:    if (lastPix) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      X        <= '0;
      Y        <= '0;
      Colour   <= '0;
      Plot     <= 1'b0;
      Busy     <= 1'b0;
      cx       <= '0;
      cy       <= '0;
      target   <= '0;
      shownPos <= '0;
      shown    <= 1'b0;
    end else begin
      case (state)
        ERASE, DRAW: begin
          X      <= xPix;
          Y      <= yPix;
          Colour <= pixColour;
          Plot   <= 1'b1;
          Busy   <= 1'b1;
          if (rowEnd) begin
            cx <= '0;
            cy <= lastPix ? '0 : cy + CYW'(1);
          end else begin
            cx <= cx + CXW'(1);
          end
          if (state == DRAW && lastPix) begin
            shownPos <= target;
            shown    <= 1'b1;
          end
        end
        default: begin
          Plot <= 1'b0;
          Busy <= 1'b0;
          cx   <= '0;
          cy   <= '0;
          if (startSweep) target <= CurrState[1:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_character_sprite_drawer.sv
// Directed bench for character_sprite_drawer: lane moves, ignored codes, mid-sweep input
// changes and asynchronous reset, with pixel streams checked against hand-computed boxes.
module tb_character_sprite_drawer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] CurrState = 4'd0;
  logic [7:0] X;
  logic [6:0] Y;
  logic [2:0] Colour;
  logic       Plot;
  logic       Busy;

  int unsigned nCompared   = 0;
  int unsigned nMismatched = 0;

  // Left edge of the box in each lane: 16 + lane*32.
  int unsigned laneX [4] = '{16, 48, 80, 112};

  character_sprite_drawer #(
    .SPRITE_W(8), .SPRITE_H(8), .LANE_X0(16), .LANE_PITCH(32), .CHAR_Y(100),
    .CHAR_COLOUR(3'b111), .BG_COLOUR(3'b000)
  ) dut (
    .Clock(Clock), .Reset(Reset), .CurrState(CurrState),
    .X(X), .Y(Y), .Colour(Colour), .Plot(Plot), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] pack(input logic p, input logic b, input logic [7:0] x,
                                       input logic [6:0] y, input logic [2:0] c);
    return {12'd0, p, b, x, y, c};
  endfunction

  // Waits up to maxWait negedges for Plot, then checks nPix pixels of a box sweep.
  // Optionally drives CurrState to chgVal right after pixel chgAt.
  task automatic expectSweep(input string tag, input int unsigned lane, input logic [2:0] col,
                             input int unsigned maxWait, input int unsigned nPix,
                             input int chgAt, input logic [3:0] chgVal);
    int unsigned waited = 0;
    int unsigned bad = 0;
    logic [31:0] firstBad = '0;
    logic [31:0] firstWant = '0;
    while (!Plot && waited < maxWait) begin
      @(negedge Clock);
      waited++;
    end
    if (!Plot) begin
      checkVal({tag, "_start"}, 32'(Plot), 32'd1);
      return;
    end
    for (int i = 0; i < int'(nPix); i++) begin
      logic [31:0] want;
      want = pack(1'b1, 1'b1, 8'(laneX[lane] + 32'(i % 8)), 7'(100 + i / 8), col);
      if (pack(Plot, Busy, X, Y, Colour) !== want) begin
        if (bad == 0) begin
          firstBad  = pack(Plot, Busy, X, Y, Colour);
          firstWant = want;
        end
        bad++;
      end
      if (i == chgAt) CurrState = chgVal;
      @(negedge Clock);
    end
    checkVal({tag, "_pixels"}, firstBad, firstWant);
    checkVal({tag, "_badcount"}, bad, 0);
  endtask

  task automatic checkIdleNow(input string tag);
    checkVal(tag, {30'd0, Plot, Busy}, 32'd0);
    @(negedge Clock);
  endtask

  task automatic idleFor(input string tag, input int unsigned n);
    int unsigned bad = 0;
    for (int i = 0; i < int'(n); i++) begin
      if (Plot || Busy) bad++;
      @(negedge Clock);
    end
    checkVal(tag, bad, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge Clock);
    checkVal("reset_outputs", pack(Plot, Busy, X, Y, Colour), 32'd0);

    // 1: first draw at lane 0, no erase
    CurrState = 4'd0;
    Reset = 1'b0;
    expectSweep("t1_draw0", 0, 3'b111, 5, 64, -1, 4'd0);
    checkIdleNow("t1_idle");

    // 2: transition code, then move to lane 1
    CurrState = 4'd4;
    idleFor("t2_transition", 20);
    CurrState = 4'd1;
    expectSweep("t2_erase0", 0, 3'b000, 5, 64, -1, 4'd0);
    expectSweep("t2_draw1", 1, 3'b111, 0, 64, -1, 4'd0);
    checkIdleNow("t2_idle");

    // 3: unused codes and the already-drawn lane do nothing
    for (int c = 10; c <= 15; c++) begin
      CurrState = 4'(c);
      idleFor($sformatf("t3_code%0d", c), 17);
    end
    CurrState = 4'd1;
    idleFor("t3_samelane", 100);

    // 4: move 1->0, then 0->1 with input changes during the sweeps
    CurrState = 4'd0;
    expectSweep("t4_erase1", 1, 3'b000, 5, 64, -1, 4'd0);
    expectSweep("t4_draw0", 0, 3'b111, 0, 64, -1, 4'd0);
    checkIdleNow("t4_idle0");
    CurrState = 4'd1;
    expectSweep("t4_erase0", 0, 3'b000, 5, 64, 5, 4'd6);
    expectSweep("t4_draw1", 1, 3'b111, 0, 64, 30, 4'd2);
    checkIdleNow("t4_gap");
    expectSweep("t4_erase1b", 1, 3'b000, 0, 64, -1, 4'd0);
    expectSweep("t4_draw2", 2, 3'b111, 0, 64, -1, 4'd0);
    checkIdleNow("t4_idle2");

    // 5: asynchronous reset in the middle of an erase
    CurrState = 4'd3;
    expectSweep("t5_erase2", 2, 3'b000, 5, 30, -1, 4'd0);
    checkVal("t5_pre_reset_plot", 32'(Plot), 32'd1);
    #2 Reset = 1'b1;
    #1 checkVal("t5_async_reset", pack(Plot, Busy, X, Y, Colour), 32'd0);
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    expectSweep("t5_draw3", 3, 3'b111, 5, 64, -1, 4'd0);
    checkIdleNow("t5_idle");

    // 6: lane 3 down to lane 0 through transition codes
    CurrState = 4'd9;
    idleFor("t6_code9", 200);
    CurrState = 4'd2;
    expectSweep("t6_erase3", 3, 3'b000, 5, 64, -1, 4'd0);
    expectSweep("t6_draw2", 2, 3'b111, 0, 64, -1, 4'd0);
    idleFor("t6_idle2", 70);
    CurrState = 4'd7;
    idleFor("t6_code7", 200);
    CurrState = 4'd1;
    expectSweep("t6_erase2", 2, 3'b000, 5, 64, -1, 4'd0);
    expectSweep("t6_draw1", 1, 3'b111, 0, 64, -1, 4'd0);
    idleFor("t6_idle1", 70);
    CurrState = 4'd5;
    idleFor("t6_code5", 200);
    CurrState = 4'd0;
    expectSweep("t6_erase1", 1, 3'b000, 5, 64, -1, 4'd0);
    expectSweep("t6_draw0", 0, 3'b111, 0, 64, -1, 4'd0);
    idleFor("t6_idle0", 70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
